// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM loader: FSM state encoding and word geometry.
package loader_pkg;

   localparam int ADDR_W_DEF     = 8;
   localparam int DATA_W_DEF     = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/word_assembler.sv
// Big-endian word assembly: shifts bytes in MSB-first and flags the final byte of a word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        R,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  in_byte,
   output logic [31:0] word,
   output logic        last_byte
);

   logic [31:0] shreg;
   logic [1:0]  byte_cnt;

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         shreg    <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         shreg    <= '0;
         byte_cnt <= '0;
      end else if (shift) begin
         shreg    <= {shreg[23:0], in_byte};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word      = shreg;
   assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rom_loader.sv
// Streams bytes into the instruction ROM as big-endian words from address 0,
// holding the fetch stage (cpu_le low) for the duration of the load.
module rom_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              R,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              cpu_le,
   output state_t            dbg_state
);

   // Handshake: a byte moves on a rising edge where in_valid && in_ready.
   // in_ready is decoded from state only, so the source may hold in_valid
   // high across the one-cycle WRITE gap between words.

   state_t            state, state_nxt;
   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W:0]   num_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [31:0]       word;
   logic              last_byte;
   logic              accept;
   logic              word_done;
   logic              load_start;

   assign load_start = (state == IDLE) && start;
   assign accept     = (state == COLLECT) && in_valid;
   assign word_done  = accept && last_byte;

   word_assembler u_word_assembler (
      .clk       (clk),
      .R         (R),
      .clear     (load_start),
      .shift     (accept),
      .in_byte   (in_byte),
      .word      (word),
      .last_byte (last_byte)
   );

   always_ff @(posedge clk or negedge R) begin
      if (!R) state <= IDLE;
      else    state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_words == '0) ? DONE : COLLECT;
         COLLECT: if (word_done) state_nxt = WRITE;
         WRITE:   state_nxt = ((word_cnt + 1'b1) == num_q) ? DONE : COLLECT;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Counter is one bit wider than the address so a full 2^ADDR_W load terminates.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         word_cnt <= '0;
         num_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         if (load_start) begin
            word_cnt <= '0;
            num_q    <= num_words;
         end else if (state == WRITE) begin
            word_cnt <= word_cnt + 1'b1;
         end
         if (word_done) begin
            addr_q  <= word_cnt[ADDR_W-1:0];
            wdata_q <= {word[23:0], in_byte};
         end
      end
   end

   assign in_ready  = (state == COLLECT);
   assign mem_we    = (state == WRITE);
   assign busy      = (state == COLLECT) || (state == WRITE);
   assign done      = (state == DONE);
   assign cpu_le    = (state == IDLE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign dbg_state = state;

endmodule

// File: doc/rom_loader.md
# rom_loader

Write-side companion to the instruction ROM: accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into consecutive ROM locations starting at address 0. The fetch path (PC, ROM, IF_ID) is the reader. This block replaces file-based preload and holds the fetch stage stalled through `cpu_le` while a program is being loaded.

## Interface
Parameters:
- `ADDR_W`, default 8: ROM address width; matches the PC width.
- `DATA_W`, default 32: instruction width; fixed at 4 bytes.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `R`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `num_words`  in  ADDR_W+1  number of words to load, 0..2^ADDR_W; latched on accepted `start`.
- `in_valid`  in  1  byte source has a byte on `in_byte`.
- `in_byte`  in  8  stream byte, MSB-first within each word.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  ROM write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  ROM write address.
- `mem_wdata`  out  DATA_W  ROM write data.
- `busy`  out  1  load in progress (COLLECT or WRITE).
- `done`  out  1  one-cycle pulse when a load completes.
- `cpu_le`  out  1  load enable for PC and IF_ID; 1 only in IDLE.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: `in_ready`=0, `busy`=0, `cpu_le`=1. On `start`=1, latch `num_words`, clear the word counter and byte counter, and go to COLLECT. If `num_words`=0, go directly to DONE instead.
- COLLECT: `in_ready`=1, `cpu_le`=0. A byte transfers when `in_valid`&&`in_ready` at a rising edge. Each transfer shifts `shreg <= {shreg[23:0], in_byte}` and increments the 2-bit byte counter. On the 4th byte, go to WRITE.
- WRITE: `in_ready`=0 and `mem_we`=1. `mem_addr` equals the word counter (low ADDR_W bits) and `mem_wdata` equals the assembled word. At the following edge, increment the word counter. If the new count equals the latched `num_words`, go to DONE; otherwise go to COLLECT.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; it neither restarts nor extends the load.
- Gaps with `in_valid`=0 stall in COLLECT indefinitely. There is no timeout.
- Word counter is ADDR_W+1 bits wide so that `num_words`=2^ADDR_W terminates correctly. The last address written is 2^ADDR_W-1. Addresses never wrap within a load.
- `mem_wdata` and `mem_addr` hold their last values outside WRITE. Only `mem_we` qualifies them.

## Timing
- Reset values (R low, applied asynchronously): state=IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `cpu_le`=1, all counters and `shreg` cleared.
- Reset mid-load: the load aborts immediately and `mem_we` drops in the same instant. Words already written remain in the ROM. A partially assembled word is discarded.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- `start` at edge t puts the block in COLLECT, with `in_ready`=1, in cycle t+1.
- Per word, with `in_valid` held high: 4 accept cycles plus 1 WRITE cycle, i.e. 5 cycles per word.
- Full load with continuous input: 5·N cycles from entering COLLECT to the DONE cycle, and `cpu_le` returns to 1 in the cycle after `done`.
- `num_words`=0: the cycle after `start` is DONE, and no `mem_we` is issued.
- The byte source must tolerate `in_ready` dropping for one cycle between words.

## Structure
- Shared package `loader_pkg`: state enum (IDLE, COLLECT, WRITE, DONE), `BYTES_PER_WORD`=4, default `ADDR_W`/`DATA_W` constants.
- One sub-module, `word_assembler`: the 32-bit shift register plus the 2-bit byte counter, with inputs shift/clear and outputs word and `last_byte`.
- The top level holds the FSM, the word counter, `num_words` latch, and the output registers.
- Integration: `cpu_le` drives the PC/IF_ID `LE`, and the mem_* outputs drive the ROM write port.

## Test plan
- Reset then idle: R low→high with no `start` -> `cpu_le`=1, `in_ready`=0, `mem_we`=0, `done`=0.
- Load 2 words, bytes E3,A0,00,01,E2,81,10,02 with continuous `in_valid` -> `mem_we` pulses at addr 0 with data E3A00001 and at addr 1 with data E2811002; `done` asserts 10 cycles after COLLECT entry; `cpu_le`=0 throughout the load.
- Same load with `in_valid` deasserted for 3 cycles after byte 2 -> identical writes, `done` 3 cycles later.
- `num_words`=0 -> `done` in the cycle after `start`, no `mem_we`. `num_words`=256 -> last write at addr FF, then `done`.
- `start` pulsed during COLLECT -> ignored; the word count and addresses are unchanged.
- R low after 6 bytes of a 3-word load -> addr 0 written, no write to addr 1, state IDLE, `cpu_le`=1 immediately.
